vga_text_ctrl: RTL and testbench

Text-mode controller between the vga timing generator and the pixel outputs. It sequences per-pixel reads from an external 80x60 character buffer and an 8x8 glyph ROM, then serialises the glyph row bits into 3-bit RGB. It also delays hsync/vsync to match the pipeline latency and overlays a blinking underline cursor.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_text_ctrl.sv | 126 ++++++++++++
 tb/tb_vga_text_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode VGA controller.
// Holds geometry, address widths, pipeline latency and the carried-control bundle.
package vga_pkg;

  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;
  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 8;
  localparam int TEXT_ADDR_W = 13;
  localparam int FONT_ADDR_W = 11;
  localparam int PIPE_LAT    = 4;

  // Per-pixel side information carried alongside the memory reads.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       valid;
    logic       hit;
    logic [2:0] xs;
  } ctrl_t;

  // row*80 + col using shifts only; result wraps to the address width.
  function automatic logic [TEXT_ADDR_W-1:0] cell_addr(
    input logic [6:0] row,
    input logic [6:0] col
  );
    logic [TEXT_ADDR_W-1:0] r;
    r = {{(TEXT_ADDR_W-7){1'b0}}, row};
    return (r << 6) + (r << 4) + {{(TEXT_ADDR_W-7){1'b0}}, col};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register of width W and depth D, advancing on pix_en.
// Ports: clk, rst (async high), pix_en, d (input word), q (word from D ticks ago).
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else if (pix_en) begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/vga_text_ctrl.sv
// Text-mode pixel pipeline: char buffer -> glyph ROM -> RGB, with delayed syncs
// and a blinking underline cursor. Ports: timing inputs (x,y,valid,syncs,newframe),
// cursor controls, text/font memory address+data, RGB and delayed sync outputs.
module vga_text_ctrl
  import vga_pkg::*;
#(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 60,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] FG           = 3'b111,
  parameter logic [2:0] BG           = 3'b000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   valid,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   newframe,
  input  logic [6:0]             cursor_col,
  input  logic [5:0]             cursor_row,
  input  logic                   cursor_en,
  output logic [TEXT_ADDR_W-1:0] text_addr,
  input  logic [7:0]             text_data,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  output logic                   R,
  output logic                   G,
  output logic                   B,
  output logic                   hsync,
  output logic                   vsync
);

  logic [6:0] row;
  logic [6:0] col;
  logic       hit;
  ctrl_t      c_in;
  ctrl_t      c_out;
  logic [2:0] gy;
  logic [7:0] blink_cnt;
  logic       blink_on;
  logic       px;
  logic [2:0] rgb;

  assign row = y[9:3];
  assign col = x[9:3];

  // Underline lives on the last scanline of the cursor cell.
  assign hit = cursor_en
             && (row == {1'b0, cursor_row})
             && (col == cursor_col)
             && (y[2:0] == 3'd7)
             && (32'(cursor_row) < ROWS)
             && (32'(cursor_col) < COLS);

  assign c_in = '{hs: hsync_in, vs: vsync_in,
                  valid: valid, hit: hit,
                  xs: x[2:0]};

  // Control arrives at the output stage aligned with font_data.
  vga_delay_line #(
    .W($bits(ctrl_t)),
    .D(PIPE_LAT)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .d      (c_in),
    .q      (c_out)
  );

  // Glyph row is needed two ticks in, when text_data is valid.
  vga_delay_line #(
    .W(3),
    .D(PIPE_LAT/2)
  ) u_gy (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .d      (y[2:0]),
    .q      (gy)
  );

  always_comb begin
    px  = font_data[3'd7 - c_out.xs];
    rgb = px ? FG : BG;
    if (c_out.hit && blink_on) rgb = FG;
    if (!c_out.valid) rgb = 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_addr <= '0;
      font_addr <= '0;
      R         <= 1'b0;
      G         <= 1'b0;
      B         <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
    end else if (pix_en) begin
      text_addr   <= cell_addr(row, col);
      font_addr   <= {text_data, gy};
      {R, G, B}   <= rgb;
      hsync       <= c_out.hs;
      vsync       <= c_out.vs;
    end
  end

  // Frame counter runs on newframe alone, independent of pix_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (newframe) begin
      if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomised bench for vga_text_ctrl against a frame-level reference model.
// Models the char buffer and glyph ROM as synchronous memories.
module tb_vga_text_ctrl;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        valid;
  logic        hsync_in;
  logic        vsync_in;
  logic        newframe;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        cursor_en;
  logic [12:0] text_addr;
  logic [7:0]  text_data = 8'd0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'd0;
  logic        R;
  logic        G;
  logic        B;
  logic        hsync;
  logic        vsync;

  vga_text_ctrl #(
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .x          (x),
    .y          (y),
    .valid      (valid),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .newframe   (newframe),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_en  (cursor_en),
    .text_addr  (text_addr),
    .text_data  (text_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .R          (R),
    .G          (G),
    .B          (B),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  always #5 clk = ~clk;

  logic [7:0] tmem [8192];
  logic [7:0] fmem [2048];

  always @(posedge clk) begin
    if (pix_en) begin
      text_data <= tmem[text_addr];
      font_data <= fmem[font_addr];
    end
  end

  typedef struct {
    int x, y, v, hs, vs, ce, cc, cr;
  } in_t;

  in_t hist [16384];
  int  tick, base, nf;
  int  exp_rgb, exp_hs, exp_vs, exp_ta, exp_fa, fa_ok;
  int  nchk, nerr;

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int taddr(input int xx, input int yy);
    return ((yy / 8) * 80 + xx / 8) % 8192;
  endfunction

  function automatic int exp_pix(input in_t e, input int b);
    int ch, gl;
    if (e.v == 0) return 0;
    if (e.ce != 0 && e.y / 8 == e.cr && e.x / 8 == e.cc
        && e.y % 8 == 7 && b == 1) return 7;
    ch = int'(tmem[taddr(e.x, e.y)]);
    gl = int'(fmem[ch * 8 + e.y % 8]);
    return ((gl >> (7 - e.x % 8)) & 1) != 0 ? 7 : 0;
  endfunction

  // One clock: update the model from the driven inputs, then check.
  task automatic step();
    in_t cur;
    int  b;
    b = (nf / BF) % 2;
    cur = '{int'(x), int'(y), int'(valid), int'(hsync_in),
            int'(vsync_in), int'(cursor_en),
            int'(cursor_col), int'(cursor_row)};
    if (pix_en) begin
      hist[tick] = cur;
      if (tick - 4 >= base) begin
        exp_rgb = exp_pix(hist[tick-4], b);
        exp_hs  = hist[tick-4].hs;
        exp_vs  = hist[tick-4].vs;
      end else begin
        exp_rgb = 0;
        exp_hs  = 0;
        exp_vs  = 0;
      end
      exp_ta = taddr(cur.x, cur.y);
      if (tick - 2 >= base) begin
        exp_fa = int'(tmem[taddr(hist[tick-2].x, hist[tick-2].y)]) * 8
               + hist[tick-2].y % 8;
        fa_ok = 1;
      end else begin
        fa_ok = 0;
      end
      tick++;
    end
    if (newframe) nf++;
    @(posedge clk);
    #1;
    check("rgb", int'({R, G, B}), exp_rgb);
    check("hsync", int'(hsync), exp_hs);
    check("vsync", int'(vsync), exp_vs);
    check("text_addr", int'(text_addr), exp_ta);
    if (fa_ok != 0) check("font_addr", int'(font_addr), exp_fa);
  endtask

  task automatic set_xy(input int xx, input int yy);
    x     = 10'(xx);
    y     = 10'(yy);
    valid = (xx < 640 && yy < 480);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_en   = 1'b1;
    newframe = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_rgb", int'({R, G, B}), 0);
    check("rst_sync", int'({hsync, vsync}), 0);
    check("rst_ta", int'(text_addr), 0);
    check("rst_fa", int'(font_addr), 0);
    repeat (3) begin
      @(negedge clk);
      pix_en = ~pix_en;
    end
    rst = 1'b0;
    nf = 0;
    base = tick;
    exp_rgb = 0; exp_hs = 0; exp_vs = 0;
    exp_ta = 0; exp_fa = 0; fa_ok = 1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en   = ($urandom_range(0, 9) < 7);
      newframe = ($urandom_range(0, 29) == 0);
      cursor_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) hsync_in = ~hsync_in;
      if ($urandom_range(0, 49) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 3) == 0)
        set_xy(int'(cursor_col) * 8 + $urandom_range(0, 7),
               int'(cursor_row) * 8 + $urandom_range(6, 7));
      else
        set_xy($urandom_range(0, 799), $urandom_range(0, 524));
      if (i == 2) begin set_xy(17, 35); pix_en = 1'b1; end
      if (i == 3) begin set_xy(639, 479); pix_en = 1'b1; end
      step();
      if (i == 2) check("ta_17_35", int'(text_addr), 322);
      if (i == 3) check("ta_639_479", int'(text_addr), 4799);
    end
  endtask

  // Scan along a line; hsync_in pulses for 96 ticks, with a pix_en stall.
  task automatic hscan_phase(input int yy);
    int xx;
    xx = 600;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      pix_en   = !(i >= 100 && i < 103);
      newframe = 1'b0;
      set_xy(xx, yy);
      hsync_in = (xx >= 656 && xx < 752);
      vsync_in = (yy >= 490 && yy < 492);
      step();
      if (pix_en) xx = (xx == 799) ? 0 : xx + 1;
    end
  endtask

  // Sweep the cursor cell and its neighbours while frames tick by.
  task automatic cursor_phase();
    cursor_col = 7'd5;
    cursor_row = 6'd2;
    cursor_en  = 1'b1;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      pix_en   = ($urandom_range(0, 9) < 8);
      newframe = (i % 37 == 0);
      set_xy(36 + i % 16, 22 + (i / 16) % 2);
      step();
    end
  endtask

  initial begin
    nchk = 0; nerr = 0; tick = 0; base = 0; nf = 0;
    exp_rgb = 0; exp_hs = 0; exp_vs = 0;
    exp_ta = 0; exp_fa = 0; fa_ok = 1;
    for (int i = 0; i < 8192; i++) tmem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) fmem[i] = 8'($urandom);
    tmem[322]   = 8'h41;
    fmem[11'h20B] = 8'b0010_0000;
    rst = 1'b1; pix_en = 1'b0; x = '0; y = '0; valid = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; newframe = 1'b0;
    cursor_col = 7'($urandom_range(0, 79));
    cursor_row = 6'($urandom_range(0, 59));
    cursor_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("init_rgb", int'({R, G, B}), 0);
    check("init_sync", int'({hsync, vsync}), 0);
    check("init_ta", int'(text_addr), 0);
    rst = 1'b0;
    random_phase(3000);
    do_reset();
    hscan_phase(100);
    hscan_phase(490);
    cursor_phase();
    do_reset();
    random_phase(1500);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
